conv_maxpool2x2: RTL and testbench

- Downstream stage of the convolution calculator; consumes its FP32 result stream in row-major order and performs 2x2, stride-2 max pooling.
- Uses one line buffer of half-row partial maxima, so a feature map is pooled in a single pass without storing it.
- Emits the pooled map row-major on a valid/ready stream, then pulses done.

---
 rtl/conv_pkg.sv | 32 +++
 rtl/fp32_max.sv | 14 +
 rtl/conv_maxpool2x2.sv | 127 ++++++++++++
 tb/tb_conv_maxpool2x2.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared FP32 constants, FSM encodings and the max-ordering helper for the
// convolution calculator's downstream stages.
package conv_pkg;

  localparam int FP_W     = 32;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

  localparam logic [FP_W-1:0]     FP_QNAN    = 32'h7FC0_0000;
  localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = 8'hFF;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic logic fp_is_nan(input logic [FP_W-1:0] x);
    return (x[FP_W-2 -: FP_EXP_W] == FP_EXP_MAX) && (x[FP_MAN_W-1:0] != '0);
  endfunction

  // Monotonic unsigned key: negatives are bit-inverted, positives get the MSB set.
  function automatic logic [FP_W-1:0] fp_key(input logic [FP_W-1:0] x);
    return x[FP_W-1] ? ~x : (x | 32'h8000_0000);
  endfunction

  function automatic logic [FP_W-1:0] fp_max(input logic [FP_W-1:0] a,
                                             input logic [FP_W-1:0] b);
    if (fp_is_nan(a) || fp_is_nan(b))
      return FP_QNAN;
    return (fp_key(b) > fp_key(a)) ? b : a;
  endfunction

endpackage

// File: rtl/fp32_max.sv
// Combinational FP32 maximum; NaN in either operand yields the canonical quiet NaN.
module fp32_max
  import conv_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  always_comb begin
    y = fp_max(a, b);
  end

endmodule

// File: rtl/conv_maxpool2x2.sv
// 2x2 stride-2 FP32 max pooling over a row-major stream, single pass with a
// line buffer holding the top-row pair maxima of each output column.
module conv_maxpool2x2
  import conv_pkg::*;
#(
  parameter int MAX_W  = 256,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_size,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_size,
  output logic              done,
  output logic              busy
);

  localparam int LB_D  = MAX_W / 2;
  localparam int LB_AW = $clog2(LB_D);

  logic [1:0]        state;
  logic [7:0]        n_lat;
  logic [7:0]        row;
  logic [7:0]        col;
  logic [DATA_W-1:0] pair_h;
  logic              last_fired;
  logic [DATA_W-1:0] lb [LB_D];

  logic              fire;
  logic [7:0]        p_lim;
  logic              in_pool;
  logic              lb_wr;
  logic              res_ld;
  logic [LB_AW-1:0]  lb_idx;
  logic [DATA_W-1:0] pair_max;
  logic [DATA_W-1:0] win_max;

  // Once the final pixel has fired, stop accepting until the frame closes.
  assign in_ready = (state == RUN) && !last_fired && (!out_valid || out_ready);
  assign fire     = in_valid && in_ready;
  assign done     = (state == DONE);
  assign busy     = (state == RUN) || (state == DONE);

  assign p_lim   = {n_lat[7:1], 1'b0};
  assign in_pool = (col < p_lim) && (row < p_lim);
  assign lb_wr   = fire && in_pool && col[0] && !row[0];
  assign res_ld  = fire && in_pool && col[0] &&  row[0];
  assign lb_idx  = LB_AW'(col >> 1);

  fp32_max u_pair_max (
    .a (pair_h),
    .b (in_data),
    .y (pair_max)
  );

  fp32_max u_win_max (
    .a (lb[lb_idx]),
    .b (pair_max),
    .y (win_max)
  );

  always_ff @(posedge clk) begin
    if (lb_wr)
      lb[lb_idx] <= pair_max;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      n_lat      <= '0;
      row        <= '0;
      col        <= '0;
      pair_h     <= '0;
      last_fired <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_size   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_lat      <= in_size;
            out_size   <= in_size >> 1;
            row        <= '0;
            col        <= '0;
            pair_h     <= '0;
            last_fired <= 1'b0;
            state      <= (in_size < 8'd2) ? DONE : RUN;
          end
        end
        RUN: begin
          if (fire) begin
            if (col == n_lat - 8'd1) begin
              col <= '0;
              row <= row + 8'd1;
              if (row == n_lat - 8'd1)
                last_fired <= 1'b1;
            end else begin
              col <= col + 8'd1;
            end
            if (in_pool && !col[0])
              pair_h <= in_data;
          end
          if (last_fired && !out_valid)
            state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // A fresh result may load in the same cycle the previous one drains.
      if (res_ld) begin
        out_data  <= win_max;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_maxpool2x2.sv
// Directed self-checking bench for conv_maxpool2x2.
module tb_conv_maxpool2x2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  in_size;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_size;
  logic        done;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [31:0] pix_q [$];
  logic [31:0] out_q [$];
  logic [31:0] exp_q [$];

  int fires, done_cnt, done_cyc, stall_seen, stall_viol, ov_seen, busy_seen;

  conv_maxpool2x2 #(.MAX_W(256), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_size   (in_size),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_size  (out_size),
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] int2fp(input int k);
    int          e;
    logic [31:0] m;
    e = 0;
    for (int i = 0; i < 31; i++)
      if (k[i]) e = i;
    m = 32'(k) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  task automatic load_ramp(input int count);
    pix_q.delete();
    for (int k = 1; k <= count; k++)
      pix_q.push_back(int2fp(k));
  endtask

  task automatic run_frame(input logic [7:0] n, input int stall_len, input int abort_after);
    int idx;
    int cyc;
    int stall_left;
    bit stall_done;
    idx = 0; cyc = 0; stall_left = 0; stall_done = 0;
    fires = 0; done_cnt = 0; done_cyc = -1;
    stall_seen = 0; stall_viol = 0; ov_seen = 0; busy_seen = 0;
    out_q.delete();
    @(posedge clk); #1;
    start = 1'b1; in_size = n; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < 2000) begin
      in_valid  = (idx < pix_q.size());
      in_data   = (idx < pix_q.size()) ? pix_q[idx] : '0;
      out_ready = (stall_left == 0);
      @(negedge clk);
      if (in_valid && in_ready) begin idx++; fires++; end
      if (out_valid) ov_seen++;
      if (out_valid && out_ready) out_q.push_back(out_data);
      if (stall_left > 0) begin
        if (out_valid) begin
          stall_seen++;
          if (in_ready) stall_viol++;
        end
        stall_left--;
      end else if (stall_len > 0 && !stall_done && out_q.size() == 1) begin
        stall_left = stall_len;
        stall_done = 1;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (busy) busy_seen++;
      cyc++;
      @(posedge clk); #1;
      if (abort_after > 0 && fires == abort_after) return;
      if (done_cyc >= 0 && cyc > done_cyc + 3) break;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (done_cyc < 0) check_eq("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_outs(input string pfx);
    check_eq({pfx, "_cnt"}, 32'(out_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check_eq($sformatf("%s_out%0d", pfx, i),
               (i < out_q.size()) ? out_q[i] : 32'hxxxx_xxxx, exp_q[i]);
    check_eq({pfx, "_done_cnt"}, 32'(done_cnt), 32'd1);
  endtask

  task automatic run_window(input string pfx, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [31:0] d, input logic [31:0] y);
    pix_q = '{a, b, c, d};
    exp_q = '{y};
    run_frame(8'd2, 0, 0);
    check_outs(pfx);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; in_size = '0; in_data = '0;
    in_valid = 1'b0; out_ready = 1'b1;
    #12;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_in_ready",  32'(in_ready),  32'd0);
    check_eq("rst_done",      32'(done),      32'd0);
    check_eq("rst_busy",      32'(busy),      32'd0);
    check_eq("rst_out_data",  out_data,       32'd0);
    check_eq("rst_out_size",  32'(out_size),  32'd0);
    rst = 1'b1;

    // N=4, free-flowing; two extra pixels must not be accepted
    load_ramp(18);
    exp_q = '{32'h40C0_0000, 32'h4100_0000, 32'h4160_0000, 32'h4180_0000};
    run_frame(8'd4, 0, 0);
    check_outs("n4");
    check_eq("n4_fires",    32'(fires),    32'd16);
    check_eq("n4_out_size", 32'(out_size), 32'd2);
    check_eq("n4_busy",     32'(busy_seen > 0), 32'd1);

    // N=5, last row and column dropped
    load_ramp(27);
    exp_q = '{32'h40E0_0000, 32'h4110_0000, 32'h4188_0000, 32'h4198_0000};
    run_frame(8'd5, 0, 0);
    check_outs("n5");
    check_eq("n5_fires",    32'(fires),    32'd25);
    check_eq("n5_out_size", 32'(out_size), 32'd2);

    // N=4 with a 5-cycle downstream stall after the first output
    load_ramp(16);
    exp_q = '{32'h40C0_0000, 32'h4100_0000, 32'h4160_0000, 32'h4180_0000};
    run_frame(8'd4, 5, 0);
    check_outs("stall");
    check_eq("stall_seen",   32'(stall_seen > 0), 32'd1);
    check_eq("stall_inrdy",  32'(stall_viol),     32'd0);
    check_eq("stall_fires",  32'(fires),          32'd16);

    run_window("zero",  32'h8000_0000, 32'h0000_0000, 32'hBF80_0000, 32'hC000_0000, 32'h0000_0000);
    run_window("nan",   32'h7F80_0001, 32'h3F80_0000, 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000);
    run_window("neginf",32'hFF80_0000, 32'hFF80_0000, 32'hFF80_0000, 32'hFF80_0000, 32'hFF80_0000);

    // N=1: nothing accepted, done the cycle after start
    pix_q = '{32'h3F80_0000};
    run_frame(8'd1, 0, 0);
    check_eq("n1_fires",    32'(fires),    32'd0);
    check_eq("n1_ov",       32'(ov_seen),  32'd0);
    check_eq("n1_done_cyc", 32'(done_cyc), 32'd0);
    check_eq("n1_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("n1_out_size", 32'(out_size), 32'd0);

    // Reset mid-frame after 7 fires, then a clean frame
    load_ramp(16);
    run_frame(8'd4, 0, 7);
    check_eq("mid_busy_pre", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("mid_out_valid", 32'(out_valid), 32'd0);
    check_eq("mid_done",      32'(done),      32'd0);
    check_eq("mid_busy",      32'(busy),      32'd0);
    check_eq("mid_in_ready",  32'(in_ready),  32'd0);
    check_eq("mid_out_size",  32'(out_size),  32'd0);
    in_valid = 1'b0;
    #3;
    rst = 1'b1;
    load_ramp(16);
    exp_q = '{32'h40C0_0000, 32'h4100_0000, 32'h4160_0000, 32'h4180_0000};
    run_frame(8'd4, 0, 0);
    check_outs("post_rst");
    check_eq("post_rst_fires", 32'(fires), 32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
